// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Bit-serial adder/subtractor built around a single 1-bit full-adder cell.
//   One operand bit is processed per clock, LSB first. A WIDTH-bit operation
//   takes WIDTH RUN cycles followed by one DONE cycle.
//
// Ports
//   clk   : single clock, all state updates on its rising edge
//   rst   : synchronous, active-high reset
//   start : request a new operation (only honoured in IDLE)
//   sub   : 0 = a + b, 1 = a - b
//   a, b  : WIDTH-bit operands, captured on the start edge
//   busy  : high while the operation is running
//   done  : one-cycle pulse when sum/cout/ovf have just been updated
//   sum   : registered result, held until the next completion or reset
//   cout  : add: carry-out of MSB; subtract: not-borrow (a >= b unsigned)
//   ovf   : two's-complement signed overflow of the result
// -----------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    // One extra bit so the counter can represent WIDTH itself (WIDTH = 64).
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] work_reg;
    logic             carry_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             busy_reg;
    logic             done_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             cout_reg;
    logic             ovf_reg;

    // Full-adder cell: two half adders plus the carry OR.
    logic ha1_sum;
    logic ha1_carry;
    logic ha2_carry;
    logic sum_bit;
    logic carry_next;
    logic last_bit;
    logic [WIDTH-1:0] work_next;

    assign ha1_sum    = a_reg[0] ^ b_reg[0];
    assign ha1_carry  = a_reg[0] & b_reg[0];
    assign sum_bit    = ha1_sum ^ carry_reg;
    assign ha2_carry  = ha1_sum & carry_reg;
    assign carry_next = ha1_carry | ha2_carry;

    // Result bits enter at the MSB and move right, so after WIDTH shifts the
    // first-computed bit sits at position 0.
    assign work_next = {sum_bit, work_reg[WIDTH-1:1]};
    assign last_bit  = (cnt_reg == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            work_reg  <= '0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_reg     <= a;
                        // Subtraction as a + ~b + 1: invert b, seed carry.
                        b_reg     <= sub ? ~b : b;
                        carry_reg <= sub;
                        cnt_reg   <= '0;
                        state_reg <= RUN;
                        busy_reg  <= 1'b1;
                    end
                end
                RUN: begin
                    work_reg  <= work_next;
                    a_reg     <= {1'b0, a_reg[WIDTH-1:1]};
                    b_reg     <= {1'b0, b_reg[WIDTH-1:1]};
                    carry_reg <= carry_next;
                    cnt_reg   <= cnt_reg + 1'b1;
                    if (last_bit) begin
                        // carry_reg here is the carry into the MSB; signed
                        // overflow is its mismatch with the carry out.
                        sum_reg   <= work_next;
                        cout_reg  <= carry_next;
                        ovf_reg   <= carry_reg ^ carry_next;
                        state_reg <= DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    done_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign sum  = sum_reg;
    assign cout = cout_reg;
    assign ovf  = ovf_reg;

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//   Self-checking bench for serial_adder (WIDTH = 8). A behavioural model
//   computes results with plain integer arithmetic and tracks the expected
//   busy/done timeline; a negedge process compares every cycle. Directed
//   sequences add hand-computed literal expectations, then randomized
//   stimulus (including resets and start pulses during RUN) exercises the rest.
// -----------------------------------------------------------------------------
module tb_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: returns {ovf, cout, sum}.
    function automatic logic [W+1:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic s);
        int unsigned  xi;
        int unsigned  yi;
        int unsigned  r;
        logic [W-1:0] res;
        logic         c;
        logic         o;
        xi = int'(x);
        yi = int'(y);
        if (!s) begin
            r   = xi + yi;
            res = r[W-1:0];
            c   = (r >= (1 << W));
            o   = (x[W-1] == y[W-1]) && (res[W-1] != x[W-1]);
        end else begin
            r   = xi - yi;
            res = r[W-1:0];
            c   = (xi >= yi);
            o   = (x[W-1] != y[W-1]) && (res[W-1] != x[W-1]);
        end
        return {o, c, res};
    endfunction

    // Timeline model: m_rem counts cycles left until the block is idle again
    // (W busy cycles, then one done cycle). Results appear on the done cycle.
    int           m_rem = 0;
    logic [W-1:0] m_sum = '0;
    logic         m_cout = 1'b0;
    logic         m_ovf = 1'b0;
    logic [W+1:0] m_pend = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_rem  = 0;
            m_sum  = '0;
            m_cout = 1'b0;
            m_ovf  = 1'b0;
        end else if (m_rem == 0) begin
            if (start) begin
                m_pend = ref_op(a, b, sub);
                m_rem  = W + 1;
            end
        end else begin
            m_rem = m_rem - 1;
            if (m_rem == 1) begin
                {m_ovf, m_cout, m_sum} = m_pend;
                $display("[TB] t=%0t result sum=%02h cout=%0b ovf=%0b",
                         $time, m_sum, m_cout, m_ovf);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", busy, m_rem >= 2);
            check("done", done, m_rem == 1);
            check("sum",  sum,  m_sum);
            check("cout", cout, m_cout);
            check("ovf",  ovf,  m_ovf);
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || done) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle_timeout", (busy || done), 1'b0);
    endtask

    // One operation with literal expectations for latency, busy length,
    // done width and result.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb2, input logic ts,
                          input logic [W-1:0] es, input logic ec, input logic eo,
                          input string nm);
        int n;
        int nbusy;
        wait_idle();
        a = ta;
        b = tb2;
        sub = ts;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        nbusy = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
            if (busy) nbusy++;
        end
        $display("[TB] op %s a=%02h b=%02h sub=%0b -> sum=%02h cout=%0b ovf=%0b after %0d cycles",
                 nm, ta, tb2, ts, sum, cout, ovf, n);
        check({nm, "_latency"}, n, W + 1);
        check({nm, "_busy_len"}, nbusy, W);
        check({nm, "_sum"}, sum, es);
        check({nm, "_cout"}, cout, ec);
        check({nm, "_ovf"}, ovf, eo);
        @(negedge clk);
        check({nm, "_done_width"}, done, 1'b0);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return 8'h00;
            1:       return 8'h7F;
            2:       return 8'h80;
            3:       return 8'hFF;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        logic [W-1:0] ca;
        logic [W-1:0] cb;
        logic         cs;
        logic [W+1:0] r;
        logic [W-1:0] held;
        int           nd;
        int           last_t;

        rst = 1'b1;
        start = 1'b0;
        sub = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_sum", sum, 8'h00);

        run_op(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, "add_0f_01");
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "add_ff_01");
        run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "add_7f_01");
        run_op(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, "sub_05_07");
        run_op(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, "sub_80_01");

        // Input changes and a start pulse during RUN must not disturb the op.
        wait_idle();
        a = 8'h12;
        b = 8'h34;
        sub = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b1;
        a = 8'hFF;
        b = 8'hFF;
        sub = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        nd = 0;
        held = '0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done) begin
                nd++;
                held = sum;
                check("ignore_start_cout", cout, 1'b0);
            end
        end
        $display("[TB] op ignore_start 12+34 -> sum=%02h dones=%0d", held, nd);
        check("ignore_start_dones", nd, 1);
        check("ignore_start_sum", held, 8'h46);

        // Reset in the third RUN cycle aborts without a done pulse.
        wait_idle();
        a = 8'h55;
        b = 8'h22;
        sub = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        $display("[TB] op abort_reset -> busy=%0b done=%0b sum=%02h", busy, done, sum);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_sum", sum, 8'h00);
        check("abort_cout", cout, 1'b0);
        check("abort_ovf", ovf, 1'b0);
        nd = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) nd++;
        end
        check("abort_no_done", nd, 0);
        run_op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, "after_reset_01_01");

        // start held high: three back-to-back operations, W+2 cycles apart.
        wait_idle();
        ca = W'($urandom);
        cb = W'($urandom);
        cs = 1'($urandom);
        a = ca;
        b = cb;
        sub = cs;
        start = 1'b1;
        nd = 0;
        last_t = -1;
        held = '0;
        for (int k = 0; k < 60 && nd < 3; k++) begin
            @(negedge clk);
            if (done) begin
                r = ref_op(ca, cb, cs);
                $display("[TB] op b2b[%0d] a=%02h b=%02h sub=%0b -> sum=%02h at cycle %0d",
                         nd, ca, cb, cs, sum, k);
                check("b2b_sum", sum, r[W-1:0]);
                check("b2b_cout", cout, r[W]);
                if (nd > 0) check("b2b_spacing", k - last_t, W + 2);
                last_t = k;
                held = sum;
                nd++;
                ca = W'($urandom);
                cb = W'($urandom);
                cs = 1'($urandom);
                a = ca;
                b = cb;
                sub = cs;
            end else if (nd > 0) begin
                check("b2b_hold", sum, held);
            end
        end
        start = 1'b0;
        check("b2b_count", nd, 3);

        // Randomized traffic: random start/operands/mode, occasional reset.
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk);
            #1;
            rst = ($urandom_range(0, 99) == 0);
            start = ($urandom_range(0, 2) == 0);
            a = pick();
            b = pick();
            sub = 1'($urandom);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        start = 1'b0;
        repeat (W + 4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have one clock; reset SHALL be synchronous and active-high.
REQ-002 Parameter WIDTH SHALL default to 8 and sets the operand and result width; legal values are 2 to 64.
REQ-003 Port clk SHALL be an input, 1 bit wide, and is the single clock; all state updates on its rising edge.
REQ-004 Port rst SHALL be an input, 1 bit wide: synchronous, active-high reset.
REQ-005 Port start SHALL be an input, 1 bit wide, requesting a new operation.
REQ-006 Port sub SHALL be an input, 1 bit wide, selecting the mode: 0 = add, 1 = subtract (a - b).
REQ-007 Port a SHALL be an input, WIDTH bits wide: operand A.
REQ-008 Port b SHALL be an input, WIDTH bits wide: operand B.
REQ-009 Port busy SHALL be an output, 1 bit wide, high while an operation is in progress.
REQ-010 Port done SHALL be an output, 1 bit wide: a one-cycle pulse when the result becomes valid.
REQ-011 Port sum SHALL be an output, WIDTH bits wide: the registered result.
REQ-012 Port cout SHALL be an output, 1 bit wide:
- add mode: carry-out of the MSB;
- subtract mode: not-borrow, i.e. 1 when a >= b unsigned.
REQ-013 Port ovf SHALL be an output, 1 bit wide: two's-complement signed overflow of the result.

Function
REQ-014 The datapath SHALL be one 1-bit full-adder cell, i.e. two half-adder stages plus a carry OR, processing one bit per clock, LSB first.
REQ-015 The FSM SHALL have states IDLE, RUN and DONE, with transitions:
- IDLE -> RUN on start=1;
- RUN -> DONE after WIDTH bit-cycles;
- DONE -> IDLE unconditionally.
REQ-016 On the edge where start=1 is sampled in IDLE, the block SHALL capture:
- a into a shift register;
- b into a shift register, bitwise inverted if sub=1;
- the carry register initialised to sub;
- the bit counter cleared to 0.
REQ-017 Changes to a, b and sub after the capture edge SHALL NOT affect the operation in progress.
REQ-018 On each RUN edge the block SHALL:
- compute s = a0 ^ b0 ^ c and next c = majority(a0, b0, c);
- shift s into the MSB of a working result register;
- shift the operand registers right by one;
- increment the counter.
REQ-019 The block SHALL record the carry-into-MSB on the RUN edge that processes bit WIDTH-1.
REQ-020 On that same edge the block SHALL:
- load sum from the working register;
- load cout from the final carry;
- load ovf = carry-into-MSB XOR final carry;
- enter DONE.
REQ-021 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE.
REQ-022 Latency: done SHALL be high in the cycle following the WIDTH-th edge after the start capture edge, i.e. WIDTH+1 cycles after start is sampled.
REQ-023 start SHALL be ignored in RUN and DONE; no queuing, no effect on the current operation.
REQ-024 sum, cout and ovf SHALL change only at completion (REQ-020) or at reset, and hold their values otherwise, including across IDLE and the next RUN.
REQ-025 Arithmetic SHALL be modulo 2^WIDTH; the internal counter SHALL be $clog2(WIDTH)+1 bits wide so WIDTH=64 does not wrap early.
REQ-026 Back-to-back operation: start held high continuously SHALL begin a new operation on the first IDLE cycle after DONE, giving a throughput of one result per WIDTH+2 cycles.

Reset
REQ-027 rst=1 at a clock edge SHALL set the FSM to IDLE and drive busy=0, done=0, sum=0, cout=0, ovf=0, and clear the counter, carry and shift registers.
REQ-028 rst SHALL take priority over start and over any state transition.
REQ-029 rst asserted mid-RUN SHALL abort the operation with no done pulse; a start after rst deasserts SHALL operate normally.

Verification (WIDTH=8)
REQ-030 Add 0x0F + 0x01 -> sum=0x10, cout=0, ovf=0; done high exactly 9 cycles after start is sampled, pulse width 1; busy high for 8 cycles.
REQ-031 Add boundaries:
- 0xFF + 0x01 -> sum=0x00, cout=1, ovf=0;
- 0x7F + 0x01 -> sum=0x80, cout=0, ovf=1.
REQ-032 Subtract:
- 0x05 - 0x07 -> sum=0xFE, cout=0, ovf=0;
- 0x80 - 0x01 -> sum=0x7F, cout=1, ovf=1.
REQ-033 Start 0x12 + 0x34, then during RUN pulse start and change a=0xFF, b=0xFF, sub=1 -> only one done, sum=0x46, cout=0.
REQ-034 Reset in the 3rd RUN cycle -> no done, all outputs 0 next cycle; then 0x01 + 0x01 -> sum=0x02 with normal latency.
REQ-035 start held high for 3 operations -> done pulses spaced exactly 10 cycles apart; sum holds between pulses.
